bram_burst_ctrl: RTL

- Initiator-side controller for the single-port synchronous BRAM.
  - BRAM contract: write when we=1 at the clock edge; dout = ram[addr] one edge after addr is sampled.
- Accepts burst read/write commands on a valid/ready interface.
- Streams write data in, and read data out, over valid/ready channels.
- Drives the BRAM port, absorbing its read latency with a credit-controlled 4-entry output FIFO.
- Sits between a host bus/UART loader and the BRAM.

---
 rtl/bram_burst_ctrl_if.sv | 31 +++
 rtl/bram_burst_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/bram_burst_ctrl_if.sv
// Host-side channels of the BRAM burst controller:
// command, write-beat and read-beat valid/ready streams.
interface bram_burst_ctrl_if #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output wr_valid, wr_data, rd_ready,
        input  cmd_ready, wr_ready, rd_valid, rd_data
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  wr_valid, wr_data, rd_ready,
        output cmd_ready, wr_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/bram_burst_ctrl.sv
// Burst read/write initiator for a single-port synchronous BRAM;
// read latency is absorbed by a credit-limited 4-entry output FIFO.
module bram_burst_ctrl #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    bram_burst_ctrl_if.slave      bus,
    output logic                  busy_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_din_o,
    input  logic [DATA_WIDTH-1:0] mem_dout_i
);
    typedef enum logic [1:0] {
        IDLE, WRITE, READ, DRAIN
    } state_e;

    state_e                state_q;
    logic                  cmd_ready_q;
    logic                  wr_ready_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_din_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  rem_q;
    // [0]: address on BRAM port, [1]: data on mem_dout
    logic [1:0]            pipe_q;
    logic [DATA_WIDTH-1:0] fifo_q [4];
    logic [1:0]            wptr_q;
    logic [1:0]            rptr_q;
    logic [2:0]            cnt_q;

    logic       cmd_fire;
    logic       wr_fire;
    logic       pop;
    logic       capture;
    logic [2:0] inflight;
    logic       credit;
    logic       issue;

    assign cmd_fire = bus.cmd_valid & cmd_ready_q;
    assign wr_fire  = bus.wr_valid & wr_ready_q;
    assign pop      = (cnt_q != 3'd0) & bus.rd_ready;
    assign capture  = pipe_q[1];
    assign inflight = {2'b0, pipe_q[0]} + {2'b0, pipe_q[1]};
    assign credit   = (cnt_q + inflight) < 3'd4;
    assign issue    = (state_q == IDLE && cmd_fire && !bus.cmd_write)
                   || (state_q == READ && credit);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            wr_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            addr_q      <= '0;
            rem_q       <= '0;
            pipe_q      <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
            for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
        end else begin
            mem_we_q <= 1'b0;
            pipe_q   <= {pipe_q[0], issue};
            if (capture) begin
                fifo_q[wptr_q] <= mem_dout_i;
                wptr_q         <= wptr_q + 2'd1;
            end
            if (pop) rptr_q <= rptr_q + 2'd1;
            cnt_q <= cnt_q + {2'b0, capture} - {2'b0, pop};

            unique case (state_q)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_fire) begin
                        cmd_ready_q <= 1'b0;
                        if (bus.cmd_write) begin
                            state_q    <= WRITE;
                            wr_ready_q <= 1'b1;
                            addr_q     <= bus.cmd_addr;
                            rem_q      <= bus.cmd_len;
                        end else begin
                            mem_addr_q <= bus.cmd_addr;
                            addr_q     <= bus.cmd_addr + ADDR_WIDTH'(1);
                            rem_q      <= bus.cmd_len - LEN_WIDTH'(1);
                            state_q    <= (bus.cmd_len == '0) ? DRAIN : READ;
                        end
                    end
                end
                WRITE: begin
                    if (wr_fire) begin
                        mem_we_q   <= 1'b1;
                        mem_addr_q <= addr_q;
                        mem_din_q  <= bus.wr_data;
                        addr_q     <= addr_q + ADDR_WIDTH'(1);
                        rem_q      <= rem_q - LEN_WIDTH'(1);
                        if (rem_q == '0) begin
                            state_q     <= IDLE;
                            wr_ready_q  <= 1'b0;
                            cmd_ready_q <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (issue) begin
                        mem_addr_q <= addr_q;
                        addr_q     <= addr_q + ADDR_WIDTH'(1);
                        rem_q      <= rem_q - LEN_WIDTH'(1);
                        if (rem_q == '0) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pipe_q == 2'b00 && cnt_q == 3'd0) begin
                        state_q     <= IDLE;
                        cmd_ready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.wr_ready  = wr_ready_q;
    assign bus.rd_valid  = (cnt_q != 3'd0);
    assign bus.rd_data   = fifo_q[rptr_q];
    assign busy_o        = (state_q != IDLE);
    assign mem_we_o      = mem_we_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_din_o     = mem_din_q;
endmodule
